// File: rtl/serial_modadd_ctrl.sv
// serial_modadd_ctrl: bit-serial (a + b) mod q using one shared full-adder slice.
// One pass forms a + b, a second forms sum - q, and the reduced value is selected.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic C,
  output logic S
);
  assign S = A ^ B ^ Cin;
  assign C = (A & B) | (Cin & (A ^ B));
endmodule

module serial_modadd_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SUB, S_DONE} state_t;
  state_t         state_q;
  logic [W-1:0]   op_a_q, op_b_q, modq_q, sum_q, diff_q, result_q;
  logic [CW-1:0]  cnt_q;
  logic           cf_q, c_add_q, done_q;
  logic           fa_a, fa_b, fa_c, fa_s, last;
  logic [W-1:0]   sum_rot_d, diff_d;
  assign last      = cnt_q == CW'(W - 1);
  assign fa_a      = state_q == S_SUB ? sum_q[0] : op_a_q[0];
  assign fa_b      = state_q == S_SUB ? ~modq_q[0] : op_b_q[0];
  assign sum_rot_d = {sum_q[0], sum_q[W-1:1]};
  assign diff_d    = {fa_s, diff_q[W-1:1]};
  full_adder u_fa (.A(fa_a), .B(fa_b), .Cin(cf_q), .C(fa_c), .S(fa_s));
  assign ready  = state_q == S_IDLE;
  assign busy   = state_q == S_ADD || state_q == S_SUB;
  assign done   = done_q;
  assign result = result_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      modq_q   <= '0;
      sum_q    <= '0;
      diff_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      cf_q     <= 1'b0;
      c_add_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          op_a_q  <= a;
          op_b_q  <= b;
          modq_q  <= q;
          cf_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_ADD;
        end
        S_ADD: begin
          // carry is forced to 1 at the pass boundary: sum + ~q + 1 = sum - q
          cf_q   <= last ? 1'b1 : fa_c;
          sum_q  <= {fa_s, sum_q[W-1:1]};
          op_a_q <= op_a_q >> 1;
          op_b_q <= op_b_q >> 1;
          cnt_q  <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            c_add_q <= fa_c;
            state_q <= S_SUB;
          end
        end
        S_SUB: begin
          cf_q   <= fa_c;
          diff_q <= diff_d;
          sum_q  <= sum_rot_d;
          modq_q <= modq_q >> 1;
          cnt_q  <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            result_q <= (c_add_q | fa_c) ? diff_d : sum_rot_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_modadd_ctrl.sv
// tb_serial_modadd_ctrl: vector table plus corner sequences for the serial modular adder.
// Expected results are queued at start and popped when done pulses.
module tb_serial_modadd_ctrl;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, q = '0;
  logic ready, busy, done;
  logic [W-1:0] result;
  int checks = 0, failures = 0;
  int q_exp[$];
  typedef struct { int a; int b; int q; int exp; } vec_t;
  vec_t vecs[10];

  serial_modadd_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .q(q),
    .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got result=%0d want no done", result);
      end else chk("result", int'(result), q_exp.pop_front());
    end
  end

  task automatic start_op(input int va, input int vb, input int vq, input int exp);
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", int'(ready), 1);
    a = W'(va);
    b = W'(vb);
    q = W'(vq);
    start = 1'b1;
    q_exp.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  // entered one cycle after the start edge; done is due 2W edges later
  task automatic wait_done(input string tag);
    int lat = 0, bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 2 * W);
    chk({tag, "_busy_cycles"}, bcnt, 2 * W);
    chk({tag, "_ready_in_done"}, int'(ready), 0);
    chk({tag, "_busy_in_done"}, int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{7, 9, 13, 3};
    vecs[1] = '{5, 4, 13, 9};
    vecs[2] = '{6, 7, 13, 0};
    vecs[3] = '{12, 12, 13, 11};
    vecs[4] = '{0, 0, 13, 0};
    vecs[5] = '{14, 14, 15, 13};
    vecs[6] = '{3, 4, 7, 0};
    vecs[7] = '{0, 1, 2, 1};
    vecs[8] = '{1, 1, 2, 0};
    vecs[9] = '{2, 5, 11, 7};
    #3;
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // back-to-back: each start lands on the first ready cycle after done
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].exp);
      wait_done($sformatf("vec%0d", i));
      @(negedge clk);
    end
    chk("ready_after_done", int'(ready), 1);
    chk("done_after_done", int'(done), 0);
    begin
      int lat = 0, bseen = 0;
      start_op(7, 9, 13, 3);
      while (!done && lat < 100) begin
        if (lat == 3) begin
          start = 1'b1;
          a = 4'd1;
          b = 4'd1;
        end else start = 1'b0;
        @(negedge clk);
        lat++;
      end
      chk("ignored_busy_latency", lat, 2 * W);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ignored_done_ready", int'(ready), 1);
      for (int i = 0; i < 12; i++) begin
        if (busy) bseen++;
        @(negedge clk);
      end
      chk("ignored_no_restart", bseen, 0);
    end
    start_op(5, 6, 13, 11);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    q_exp.delete();
    #1;
    chk("midrst_ready", int'(ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_result", int'(result), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    start_op(1, 2, 13, 3);
    wait_done("after_rst");
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_modadd_ctrl.md
Name: serial_modadd_ctrl

Overview:
- Sequencer that computes (a + b) mod q bit-serially through one shared FullAdder cell (ports A, B, Cin, C, S).
- Pass 1 forms the sum; pass 2 forms sum − q; the controller then selects the reduced value.
- Area-minimal modular-add engine for the NTT butterfly datapath, where latency is traded for a single 1-bit adder slice.

Parameters:
- W, 16, operand/modulus width in bits (W ≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; accepted only when ready=1.
- a  input  W  addend, required a < q.
- b  input  W  addend, required b < q.
- q  input  W  modulus, required q ≥ 2.
- ready  output  1  high in IDLE only.
- busy  output  1  high in ADD and SUB.
- done  output  1  one-cycle pulse when result updates.
- result  output  W  (a+b) mod q; holds until the next done.

Behaviour:
- Reset (async, rst=1): state=IDLE, ready=1, busy=0, done=0, result=0, carry flop=0, all shift registers cleared. Takes effect immediately, including mid-operation. The partial result is discarded and no done is issued.
- State registers: opA, opB, modQ (W-bit shift right); sumR (W-bit shift right, fill at MSB); diffR (W-bit); carry flop cf; c_add flag.
- IDLE:
  - start=1 on edge k: load opA=a, opB=b, modQ=q, cf=0, bit counter=0; go to ADD.
  - Inputs are sampled only at this edge.
  - start while not in IDLE is ignored (no queueing).
- ADD, W cycles (k+1 .. k+W):
  - FullAdder inputs A=opA[0], B=opB[0], Cin=cf.
  - Each edge: cf←C; sumR←{S, sumR[W-1:1]}; opA and opB shift right; counter increments.
  - On the last ADD edge: c_add←C; cf←1 (two's-complement +1); counter←0; go to SUB.
- SUB, W cycles (k+W+1 .. k+2W):
  - FullAdder inputs A=sumR[0], B=~modQ[0], Cin=cf.
  - Each edge: cf←C; diffR←{S, diffR[W-1:1]}; sumR rotates right (its original value must be preserved for selection); modQ shifts right.
- Selection, on the last SUB edge:
  - ge = c_add | C_final.
  - result ← ge ? diffR_final : sumR_original.
  - done←1; go to DONE.
  - Equality (sum == q) selects diff and yields 0.
- DONE, cycle k+2W+1:
  - done=1, ready=0, busy=0; return to IDLE next edge.
  - A start during DONE is ignored.
- Latency and throughput:
  - done asserts 2W+1 cycles after the start edge.
  - Minimum start-to-start spacing is 2W+2 cycles.
- Out-of-range inputs (a ≥ q or b ≥ q): exactly one conditional subtraction is performed. The output is deterministic but not guaranteed reduced; it is not flagged.
- Width rules:
  - The sum is W+1 bits: c_add is the MSB.
  - diff = low W bits of {c_add, sum} − q; valid whenever ge=1.
- Outputs ready, busy and done are decoded from registered state (glitch-free).
- result changes only on the done edge.

Test Plan:
- W=4, q=13, a=7, b=9 → sum 16, c_add=1 → result=3; done at start+9; busy high for 8 cycles.
- W=4, q=13, a=5, b=4 → sum 9 < 13 → result=9; ge=0.
- W=4, q=13, a=6, b=7 → sum == q → result=0 (equality boundary).
- W=4, q=13, a=12, b=12 → sum 24 (5-bit overflow) → result=11. Then back-to-back start at the first ready cycle with a=0, b=0 → result=0.
- Start pulsed again at start+3 (busy) and in the DONE cycle → both ignored. result=3 for the first op (a=7, b=9); no extra done pulse.
- rst asserted at start+5 mid-ADD → immediately ready=1, busy=0, result=0, no done. A new start with a=1, b=2 then yields result=3.
